// File: rtl/nor_chk_pkg.sv
// nor_chk_pkg -- shared types and constants for the NOR gate stimulus checker.
//   state_e       : checker FSM states (also exported on the debug port)
//   NUM_VECTORS   : number of {a,b} vectors in one sweep
//   ERR_MAX       : saturation value of the mismatch counter
//   nor_expected  : reference NOR response for a given stimulus
// Optional feature macro used by the top: NOR_CHK_FIRST_FAIL_EN.
package nor_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  localparam int         NUM_VECTORS = 4;
  localparam logic [3:0] ERR_MAX     = 4'd15;

  function automatic logic nor_expected(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/nor_chk_settle_cnt.sv
// nor_chk_settle_cnt -- 4-bit settle down-counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val into the counter (has priority over tick)
//   load_val  : value to load
//   tick      : decrement by one (holds at zero)
//   zero      : counter currently equals zero
module nor_chk_settle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/nor_stim_checker.sv
// nor_stim_checker -- drives the four {a,b} vectors into an external NOR gate,
// waits SETTLE_CYCLES, checks y against ~(a|b) and counts mismatches.
// Parameters:
//   SETTLE_CYCLES : idle cycles between driving a/b and sampling y (0..15)
//   NUM_PASSES    : full 4-vector sweeps per run (1..15)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : run request, sampled only in IDLE
//   a, b            : registered stimulus to the gate
//   y               : gate response
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse (during FIN) when a run completes
//   pass            : last completed run had zero mismatches
//   err_count       : saturating mismatch count of current/last run
//   vec_idx         : index of the vector being applied (a=[1], b=[0])
//   first_fail(_vld): vector index of the first mismatch of the run
//                     (present only when NOR_CHK_FIRST_FAIL_EN is defined)
//   state_dbg       : current FSM state, for observation only
// Handshake: start is a level request. It is accepted only when the FSM is in
// IDLE (busy=0); while busy it is ignored, never queued. Each accepted start
// produces exactly one done pulse unless rst aborts the run first.
module nor_stim_checker
  import nor_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] vec_idx,
`ifdef NOR_CHK_FIRST_FAIL_EN
  output logic [1:0] first_fail,
  output logic       first_fail_vld,
`endif
  output state_e     state_dbg
);

  // Counter is loaded with SETTLE_CYCLES-1 so that SETTLE exits on the cycle
  // the counter reads zero, giving exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_e     state;
  logic [3:0] pass_cnt;
  logic       settle_zero;
  logic       mismatch;
  logic [3:0] err_next;

  assign state_dbg = state;

  nor_chk_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_DRIVE),
    .load_val (SETTLE_LOAD),
    .tick     (state == ST_SETTLE),
    .zero     (settle_zero)
  );

  always_comb begin
    mismatch = (y != nor_expected(a, b));
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 4'd0;
      vec_idx        <= 2'd0;
      pass_cnt       <= 4'd0;
`ifdef NOR_CHK_FIRST_FAIL_EN
      first_fail     <= 2'd0;
      first_fail_vld <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_DRIVE;
            busy      <= 1'b1;
            err_count <= 4'd0;
            pass      <= 1'b0;
            vec_idx   <= 2'd0;
            pass_cnt  <= 4'd0;
`ifdef NOR_CHK_FIRST_FAIL_EN
            first_fail     <= 2'd0;
            first_fail_vld <= 1'b0;
`endif
          end
        end
        ST_DRIVE: begin
          a     <= vec_idx[1];
          b     <= vec_idx[0];
          state <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
        end
        ST_SETTLE: begin
          if (settle_zero) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_count <= err_next;
`ifdef NOR_CHK_FIRST_FAIL_EN
          if (mismatch && !first_fail_vld) begin
            first_fail     <= vec_idx;
            first_fail_vld <= 1'b1;
          end
`endif
          if (vec_idx != LAST_VEC) begin
            vec_idx <= vec_idx + 2'd1;
            state   <= ST_DRIVE;
          end else begin
            vec_idx <= 2'd0;
            if (pass_cnt == LAST_PASS) begin
              // done and pass are registered here so they are visible in FIN.
              state <= ST_FIN;
              done  <= 1'b1;
              pass  <= (err_next == 4'd0);
            end else begin
              pass_cnt <= pass_cnt + 4'd1;
              state    <= ST_DRIVE;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_stim_checker.sv
// tb_nor_stim_checker -- directed bench for nor_stim_checker.
// Three instances: [0] defaults, [1] NUM_PASSES=15, [2] SETTLE_CYCLES=0.
// Each drives its own NOR model whose output can be ideal, stuck-0 or stuck-1.
module tb_nor_stim_checker;
  import nor_chk_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] start, a, b, y, busy, done, pass;
  logic [3:0] err [3];
  logic [1:0] vidx [3];
  state_e     st [3];
  logic [1:0] ymode [3];  // 0 ideal, 1 stuck-at-0, 2 stuck-at-1
`ifdef NOR_CHK_FIRST_FAIL_EN
  logic [1:0] ff [3];
  logic [2:0] ffv;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_model
    assign y[g] = (ymode[g] == 2'd0) ? ~(a[g] | b[g]) :
                  (ymode[g] == 2'd1) ? 1'b0 : 1'b1;
  end

  nor_stim_checker dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .y(y[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]),
    .vec_idx(vidx[0]),
`ifdef NOR_CHK_FIRST_FAIL_EN
    .first_fail(ff[0]), .first_fail_vld(ffv[0]),
`endif
    .state_dbg(st[0])
  );

  nor_stim_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(15)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .y(y[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
    .vec_idx(vidx[1]),
`ifdef NOR_CHK_FIRST_FAIL_EN
    .first_fail(ff[1]), .first_fail_vld(ffv[1]),
`endif
    .state_dbg(st[1])
  );

  nor_stim_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]), .y(y[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]),
    .vec_idx(vidx[2]),
`ifdef NOR_CHK_FIRST_FAIL_EN
    .first_fail(ff[2]), .first_fail_vld(ffv[2]),
`endif
    .state_dbg(st[2])
  );

  // scoreboard counters
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start instance i, run up to max_cyc cycles after the start-sampling edge.
  // With hold=1, start stays high until done is seen.
  task automatic run(input int i, input int max_cyc, input bit hold,
                     output int done_cyc, output int done_cnt, output int settle_cnt);
    done_cyc   = 0;
    done_cnt   = 0;
    settle_cnt = 0;
    @(negedge clk);
    start[i] = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (!hold) start[i] = 1'b0;
      if (st[i] == ST_SETTLE) settle_cnt++;
      if (done[i]) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        start[i] = 1'b0;
      end
    end
  endtask

  int dcyc, dcnt, scnt;

  initial begin
    rst   = 1'b1;
    start = 3'b000;
    for (int i = 0; i < 3; i++) ymode[i] = 2'd0;

    // --- reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_outs", i),
          {a[i], b[i], busy[i], done[i], pass[i], err[i], vidx[i]}, 32'd0);
      chk($sformatf("rst%0d_state", i), st[i], ST_IDLE);
`ifdef NOR_CHK_FIRST_FAIL_EN
      chk($sformatf("rst%0d_ff", i), {ff[i], ffv[i]}, 32'd0);
`endif
    end
    rst = 1'b0;

    // --- ideal model, defaults: vector order, done in cycle 17
    @(negedge clk);
    start[0] = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (cyc % 4 == 0) begin
        chk($sformatf("ideal_ab_c%0d", cyc), {a[0], b[0]}, 32'(cyc / 4 - 1));
        chk($sformatf("ideal_vidx_c%0d", cyc), vidx[0], 32'(cyc / 4 - 1));
      end
      if (cyc >= 16) chk($sformatf("ideal_done_c%0d", cyc), done[0], (cyc == 17) ? 32'd1 : 32'd0);
    end
    chk("ideal_fin_busy", busy[0], 1);
    chk("ideal_fin_pass", pass[0], 1);
    @(negedge clk);
    chk("ideal_idle_busy_done", {busy[0], done[0]}, 0);
    chk("ideal_hold_ab", {a[0], b[0]}, 2'b11);
    chk("ideal_hold_pass_err", {pass[0], err[0]}, {1'b1, 4'd0});
    chk("ideal_state", st[0], ST_IDLE);

    // --- y stuck-at-0: only vector 00 mismatches
    ymode[0] = 2'd1;
    run(0, 25, 1'b0, dcyc, dcnt, scnt);
    chk("sa0_done_cyc", dcyc, 17);
    chk("sa0_done_cnt", dcnt, 1);
    chk("sa0_err", err[0], 1);
    chk("sa0_pass", pass[0], 0);
`ifdef NOR_CHK_FIRST_FAIL_EN
    chk("sa0_ff", {ff[0], ffv[0]}, {2'b00, 1'b1});
`endif

    // --- rst during SETTLE of vector 2 (cycles 10-11)
    ymode[0] = 2'd0;
    @(negedge clk);
    start[0] = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("abort_pre_state", st[0], ST_SETTLE);
    chk("abort_pre_vidx", vidx[0], 2);
    rst = 1'b1;
    #1;
    chk("abort_outs", {a[0], b[0], busy[0], done[0], pass[0], err[0], vidx[0]}, 0);
    chk("abort_state", st[0], ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done[0] || busy[0]) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run(0, 25, 1'b0, dcyc, dcnt, scnt);
    chk("rerun_done_cyc", dcyc, 17);
    chk("rerun_pass_err", {pass[0], err[0]}, {1'b1, 4'd0});

    // --- start held high for the whole run
    run(0, 40, 1'b1, dcyc, dcnt, scnt);
    chk("hold_done_cyc", dcyc, 17);
    chk("hold_done_cnt", dcnt, 1);
    chk("hold_idle", {busy[0], st[0]}, {1'b0, ST_IDLE});

    // --- y stuck-at-1, 15 passes: 45 raw mismatches saturate at 15
    ymode[1] = 2'd2;
    run(1, 260, 1'b0, dcyc, dcnt, scnt);
    chk("sa1_done_cyc", dcyc, 15 * 16 + 1);
    chk("sa1_done_cnt", dcnt, 1);
    chk("sa1_err_sat", err[1], 15);
    chk("sa1_pass", pass[1], 0);
`ifdef NOR_CHK_FIRST_FAIL_EN
    chk("sa1_ff", {ff[1], ffv[1]}, {2'b01, 1'b1});
`endif

    // --- SETTLE_CYCLES=0: done in cycle 9, never enters SETTLE
    run(2, 15, 1'b0, dcyc, dcnt, scnt);
    chk("s0_done_cyc", dcyc, 9);
    chk("s0_settle_cnt", scnt, 0);
    chk("s0_pass_err", {pass[2], err[2]}, {1'b1, 4'd0});
    ymode[2] = 2'd1;
    run(2, 15, 1'b0, dcyc, dcnt, scnt);
    chk("s0_sa0_err", {pass[2], err[2]}, {1'b0, 4'd1});

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
